// File: rtl/box_scanner.sv
// ==========================================================================
// box_scanner - shadow 160x120 framebuffer with square-region colour scan.
// Option macro: BOX_SCANNER_MASK_EN (adds match_mask input).  Rev 1.0
// ==========================================================================
`default_nettype none

module box_scanner #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                plot,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                start,
    input  logic [7:0]          sx,
    input  logic [6:0]          sy,
    input  logic [4:0]          size,
    input  logic [COLOUR_W-1:0] match_colour,
`ifdef BOX_SCANNER_MASK_EN
    input  logic [COLOUR_W-1:0] match_mask,
`endif
    output logic                busy,
    output logic                done,
    output logic                hit,
    output logic [9:0]          hit_count,
    output logic [7:0]          first_x,
    output logic [6:0]          first_y
);

    localparam int         DEPTH  = SCREEN_W * SCREEN_H;
    localparam int         ADDR_W = $clog2(DEPTH);
    localparam logic [8:0] W9     = 9'(SCREEN_W);
    localparam logic [8:0] H9     = 9'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [8:0]            col, row, col_first, col_last, row_last;
    logic [COLOUR_W-1:0]   target;
`ifdef BOX_SCANNER_MASK_EN
    logic [COLOUR_W-1:0]   mask_q;
`endif
    logic                  drain_cnt;
    logic                  rd_valid;
    logic [7:0]            rd_x;
    logic [6:0]            rd_y;
    logic [COLOUR_W-1:0]   rd_data;
    logic [COLOUR_W-1:0]   mem [DEPTH];

    logic                  plot_ok, pix_ok, scan_read, is_match;
    logic [ADDR_W-1:0]     wr_addr, rd_addr, addr;

    // Plots own the single RAM port; a scan read only happens on free cycles.
    assign plot_ok   = plot && ({1'b0, x} < W9) && ({2'b0, y} < H9);
    assign pix_ok    = (col < W9) && (row < H9);
    assign scan_read = (state == S_SCAN) && !plot_ok && pix_ok;
    assign wr_addr   = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    assign rd_addr   = ADDR_W'(row) * ADDR_W'(SCREEN_W) + ADDR_W'(col);
    assign addr      = plot_ok ? wr_addr : rd_addr;

`ifdef BOX_SCANNER_MASK_EN
    assign is_match  = ((rd_data ^ target) & mask_q) == '0;
`else
    assign is_match  = (rd_data == target);
`endif

    // Contents survive reset on purpose: only configuration initialises them.
    always_ff @(posedge CLOCK_50) begin
        if (plot_ok) begin
            mem[addr] <= colour;
        end
        rd_data <= mem[addr];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            hit_count <= '0;
            first_x   <= '0;
            first_y   <= '0;
            col       <= '0;
            row       <= '0;
            col_first <= '0;
            col_last  <= '0;
            row_last  <= '0;
            target    <= '0;
`ifdef BOX_SCANNER_MASK_EN
            mask_q    <= '0;
`endif
            drain_cnt <= 1'b0;
            rd_valid  <= 1'b0;
            rd_x      <= '0;
            rd_y      <= '0;
        end else begin
            rd_valid <= scan_read;
            if (scan_read) begin
                rd_x <= col[7:0];
                rd_y <= row[6:0];
            end

            if (rd_valid && is_match) begin
                hit_count <= hit_count + 10'd1;
                if (!hit) begin
                    hit     <= 1'b1;
                    first_x <= rd_x;
                    first_y <= rd_y;
                end
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        hit       <= 1'b0;
                        hit_count <= '0;
                        first_x   <= '0;
                        first_y   <= '0;
                        target    <= match_colour;
`ifdef BOX_SCANNER_MASK_EN
                        mask_q    <= match_mask;
`endif
                        col       <= {1'b0, sx};
                        row       <= {2'b0, sy};
                        col_first <= {1'b0, sx};
                        col_last  <= {1'b0, sx} + {4'b0, size} - 9'd1;
                        row_last  <= {2'b0, sy} + {4'b0, size} - 9'd1;
                        if (size == 5'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (!plot_ok) begin
                        if (col == col_last) begin
                            col <= col_first;
                            if (row == row_last) begin
                                state     <= S_DRAIN;
                                drain_cnt <= 1'b0;
                            end else begin
                                row <= row + 9'd1;
                            end
                        end else begin
                            col <= col + 9'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Two cycles: RAM read of the last pixel, then its compare.
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_box_scanner.sv
// Bench for box_scanner: shadow pixel model plus queue of expected scan results.
`timescale 1ns/1ps
`default_nettype none

module tb_box_scanner;
    localparam int W = 160;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       resetn;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       start;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [4:0] size;
    logic [2:0] match_colour;
`ifdef BOX_SCANNER_MASK_EN
    logic [2:0] match_mask;
    logic [2:0] cur_mask = 3'b111;
`endif
    logic       busy, done, hit;
    logic [9:0] hit_count;
    logic [7:0] first_x;
    logic [6:0] first_y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [2:0] fb [W*H];

    typedef struct {
        bit hit;
        int cnt;
        int fx;
        int fy;
        int lat;
    } exp_t;
    exp_t sb[$];

    box_scanner dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .start        (start),
        .sx           (sx),
        .sy           (sy),
        .size         (size),
        .match_colour (match_colour),
`ifdef BOX_SCANNER_MASK_EN
        .match_mask   (match_mask),
`endif
        .busy         (busy),
        .done         (done),
        .hit          (hit),
        .hit_count    (hit_count),
        .first_x      (first_x),
        .first_y      (first_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit px_match(logic [2:0] p, logic [2:0] m);
`ifdef BOX_SCANNER_MASK_EN
        return ((p ^ m) & cur_mask) == 3'b000;
`else
        return p == m;
`endif
    endfunction

    function automatic exp_t model(int ax, int ay, int n, logic [2:0] m, int stalls);
        exp_t e;
        e.hit = 1'b0; e.cnt = 0; e.fx = 0; e.fy = 0;
        e.lat = (n == 0) ? 1 : n * n + 3 + stalls;
        for (int r = ay; r < ay + n; r++) begin
            for (int c = ax; c < ax + n; c++) begin
                if (c < W && r < H && px_match(fb[r*W+c], m)) begin
                    if (!e.hit) begin
                        e.hit = 1'b1; e.fx = c; e.fy = r;
                    end
                    e.cnt++;
                end
            end
        end
        return e;
    endfunction

    task automatic plot_px(int px, int py, logic [2:0] c);
        @(negedge clk);
        plot = 1'b1; x = px[7:0]; y = py[6:0]; colour = c;
        if (px < W && py < H) fb[py*W+px] = c;
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic clear_region(int ax, int ay, int w, int h);
        for (int r = ay; r < ay + h; r++)
            for (int c = ax; c < ax + w; c++)
                plot_px(c, r, 3'b000);
    endtask

    // Runs one scan; optional stall plots and an ignored start pulse while busy.
    task automatic scan(string name, int ax, int ay, int n, logic [2:0] m, int stalls, bit poke);
        exp_t e;
        int   c0, i, guard;
        sb.push_back(model(ax, ay, n, m, stalls));
        @(negedge clk);
        start = 1'b1; sx = ax[7:0]; sy = ay[6:0]; size = n[4:0]; match_colour = m;
`ifdef BOX_SCANNER_MASK_EN
        match_mask = cur_mask;
`endif
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        checks++;
        if (busy !== (n != 0)) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected %b", name, busy, (n != 0));
        end
        guard = 0;
        while (done !== 1'b1 && guard < 2000) begin
            i = cyc - c0;
            if (stalls > 0) begin
                plot = (i % 4 == 2) && (i / 4 < stalls);
                x = 8'd100; y = 7'd100; colour = 3'b011;
                if (plot) fb[100*W+100] = 3'b011;
            end
            if (poke) begin
                start = (i == 3);
                if (i == 3) begin
                    sx = 8'd0; sy = 7'd0; size = 5'd1; match_colour = ~m;
                end
            end
            @(negedge clk);
            guard++;
        end
        plot = 1'b0; start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: got no done within %0d cycles", name, guard);
            return;
        end
        checks++;
        if (cyc - c0 + 1 != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc - c0 + 1, e.lat);
        end
        checks++;
        if (busy !== 1'b0 || hit !== e.hit || hit_count !== 10'(e.cnt)) begin
            errors++;
            $display("FAIL %s result: got busy=%b hit=%b count=%0d expected busy=0 hit=%b count=%0d",
                     name, busy, hit, hit_count, e.hit, e.cnt);
        end
        checks++;
        if (first_x !== 8'(e.fx) || first_y !== 7'(e.fy)) begin
            errors++;
            $display("FAIL %s first: got (%0d,%0d) expected (%0d,%0d)",
                     name, first_x, first_y, e.fx, e.fy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || hit_count !== 10'(e.cnt) || hit !== e.hit) begin
            errors++;
            $display("FAIL %s hold: got done=%b count=%0d expected done=0 count=%0d",
                     name, done, hit_count, e.cnt);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b hit=%b expected 0 0 0", busy, done, hit);
        end
        checks++;
        if (hit_count !== 10'd0 || first_x !== 8'd0 || first_y !== 7'd0) begin
            errors++;
            $display("FAIL reset_results: got count=%0d first=(%0d,%0d) expected 0 (0,0)",
                     hit_count, first_x, first_y);
        end
    endtask

    task automatic test_single_pixel;
        plot_px(10, 20, 3'b101);
        scan("single", 8, 18, 4, 3'b101, 0, 1'b0);
        scan("size1", 10, 20, 1, 3'b101, 0, 1'b0);
    endtask

    task automatic test_zero_size;
        scan("zero", 0, 0, 0, 3'b000, 0, 1'b0);
    endtask

    task automatic test_edge_clip;
        scan("clip", 158, 118, 4, 3'b000, 0, 1'b0);
        scan("offscreen", 200, 0, 3, 3'b000, 0, 1'b0);
    endtask

    task automatic test_stall;
        plot_px(50, 50, 3'b110);
        plot_px(51, 50, 3'b110);
        plot_px(50, 51, 3'b110);
        plot_px(51, 51, 3'b110);
        scan("stall", 48, 48, 6, 3'b110, 3, 1'b0);
    endtask

    task automatic test_back_to_back;
        scan("ignore_start", 48, 48, 6, 3'b110, 0, 1'b1);
        scan("b2b", 8, 18, 4, 3'b000, 0, 1'b0);
    endtask

    task automatic test_reset_mid_scan;
        @(negedge clk);
        start = 1'b1; sx = 8'd48; sy = 7'd48; size = 5'd6; match_colour = 3'b110;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hit_count !== 10'd0 ||
            first_x !== 8'd0 || first_y !== 7'd0) begin
            errors++;
            $display("FAIL midreset: got busy=%b done=%b hit=%b count=%0d expected all 0",
                     busy, done, hit, hit_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got busy=%b expected 0", busy);
        end
        scan("after_reset", 48, 48, 6, 3'b110, 0, 1'b0);
    endtask

`ifdef BOX_SCANNER_MASK_EN
    task automatic test_mask;
        plot_px(30, 30, 3'b101);
        plot_px(31, 30, 3'b100);
        cur_mask = 3'b100;
        scan("mask", 30, 30, 2, 3'b100, 0, 1'b0);
        cur_mask = 3'b000;
        scan("mask_zero", 30, 30, 2, 3'b111, 0, 1'b0);
        cur_mask = 3'b111;
    endtask
`endif

    initial begin
        foreach (fb[i]) fb[i] = 3'b000;
        resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
        start = 1'b0; sx = '0; sy = '0; size = '0; match_colour = '0;
`ifdef BOX_SCANNER_MASK_EN
        match_mask = '0;
`endif
        repeat (3) @(negedge clk);
        test_reset;
        resetn = 1'b1;
        clear_region(8, 18, 4, 4);
        clear_region(158, 118, 2, 2);
        clear_region(48, 48, 6, 6);
        clear_region(30, 30, 2, 2);
        test_single_pixel;
        test_zero_size;
        test_edge_clip;
        test_stall;
        test_back_to_back;
        test_reset_mid_scan;
`ifdef BOX_SCANNER_MASK_EN
        test_mask;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/box_scanner.md
# box_scanner

Shadow-framebuffer reader for the 160x120 drawing path. It accepts the same plot stream (x, y, colour, plot) that the drawing logic sends to the VGA adapter and keeps a private copy in on-chip RAM. On request it scans a square region in draw order (left to right, top to bottom, from the top-left corner) and reports whether any pixel matches a target colour, how many match, and where the first match is. The game FSM uses it for collision and occupancy checks without touching the VGA adapter's own buffer.

## Interface

Parameters:

- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- COLOUR_W, 3, bits per stored pixel.

Ports:

- CLOCK_50  in  1  system clock; all logic on the rising edge.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- plot  in  1  write strobe; writes colour to (x, y) this cycle.
- x  in  8  write column; values at or above SCREEN_W are ignored.
- y  in  7  write row; values at or above SCREEN_H are ignored.
- colour  in  3  write data.
- start  in  1  scan request; sampled only in IDLE.
- sx  in  8  scan top-left column; captured on an accepted start.
- sy  in  7  scan top-left row; captured on an accepted start.
- size  in  5  side length in pixels (0–31); captured on an accepted start.
- match_colour  in  3  target colour; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- hit  out  1  at least one pixel matched.
- hit_count  out  10  number of matching pixels (max 961).
- first_x  out  8  column of the first match in scan order.
- first_y  out  7  row of the first match in scan order.

## Operation

- RAM: SCREEN_W*SCREEN_H words of COLOUR_W bits, single port, synchronous read with 1-cycle latency. Address = y*SCREEN_W + x. Initialised to 0 at configuration; not cleared by reset.
- FSM states:
  - IDLE → SCAN on start with size≠0.
  - IDLE → DONE on start with size=0.
  - SCAN → DRAIN after the last address is issued.
  - DRAIN → DONE when the final compare is registered (2 cycles).
  - DONE → IDLE after 1 cycle.
- SCAN issues one read per non-stalled cycle. The column counter runs sx..sx+size-1. On column wrap the row counter increments.
- Counter arithmetic is 9 bits wide, so sx+size never aliases.
- Pixels with column ≥ SCREEN_W or row ≥ SCREEN_H are skipped. They still consume a cycle, are never read, and never count as a match.
- Port arbitration: plot has priority over scan.
  - A valid in-range plot in any state performs the write.
  - In SCAN, a plot stalls the scan address generator for that cycle (no read issued, counters held).
  - Out-of-range plots do not stall.
- Compare stage: a returned pixel matches when it equals the captured match_colour (see Configuration).
  - On a match, hit_count increments.
  - On the first match of a scan, first_x/first_y are loaded.
- An accepted start clears hit, hit_count, first_x and first_y.
- Results hold their values from done until the next accepted start.
- start is ignored while busy. sx, sy, size and match_colour changes after capture have no effect.
- Reset mid-scan: FSM returns to IDLE immediately; outputs take their reset values; RAM contents are kept.

## Timing

- Reset values: busy=0, done=0, hit=0, hit_count=0, first_x=0, first_y=0.
- Start accepted at edge T0: busy=1 from T0+1.
- No stalls, size=N>0: done pulses in cycle T0+N²+3, with results valid in the same cycle. busy falls in that cycle.
- Each stall cycle adds exactly 1 cycle of latency.
- size=0: done pulses in cycle T0+1 with all results 0. busy stays low.
- Write then scan of the same pixel: a plot at edge Tw is visible to any read issued at Tw+1 or later.

## Configuration

- BOX_SCANNER_MASK_EN
  - Defined: adds input match_mask [2:0], captured on an accepted start. A pixel matches when (pixel & mask) == (match_colour & mask). A mask of 0 matches every in-range pixel.
  - Undefined: no match_mask port; exact equality compare.

## Test plan

- Plot colour 3'b101 at (10,20) after reset, then scan sx=8, sy=18, size=4, match 3'b101 → done at T0+19, hit=1, hit_count=1, first=(10,20).
- Scan sx=0, sy=0, size=0 → done at T0+1, busy never high, all results 0.
- Scan sx=158, sy=118, size=4 with the RAM all 0 and match 3'b000 → hit_count=4 (only in-range pixels), done at T0+19.
- Plot a 2x2 block at (50,50), scan size=6 at (48,48), assert 3 unrelated in-range plots during SCAN → hit_count=4, done at T0+42.
- Assert resetn low mid-scan, then restart → outputs 0, busy=0; the next scan still sees earlier plotted pixels.
- With BOX_SCANNER_MASK_EN, pixels 3'b101 and 3'b100, mask 3'b100, match 3'b100 → both pixels counted.
